// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and
// the shift-op classifier used by both the top level and the shifter.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand-issue and result-writeback bundle for seq_alu.
// Handshake: a beat transfers on a rising edge where valid && ready; the
// sender holds payload stable while valid && !ready, and valid never
// depends on ready.
interface seq_alu_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_ans;
  logic             out_zero;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, op, out_ready,
    input  in_ready, out_valid, out_ans, out_zero, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, op, out_ready,
    output in_ready, out_valid, out_ans, out_zero, out_carry, out_ovf
  );

endinterface

// File: rtl/alu_iter_shifter.sv
// One-bit-per-cycle shifter: start latches value/op/amount, each step
// shifts once; done flags the final step, with result_o the shifted word.
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic [SHW-1:0]   amt_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] work_q, work_d, shifted;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  always_comb begin
    shifted = work_q;
    case (op_q)
      OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    if (start_i) begin
      work_d = val_i;
      cnt_d  = amt_i;
      op_d   = op_i;
    end else if (step_i) begin
      work_d = shifted;
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= OP_SLL;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

  // The last step is the one that starts with one shift remaining.
  assign done_o   = step_i && (cnt_q == SHW'(1));
  assign result_o = shifted;

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU: single-cycle arithmetic/logic ops with a
// registered result, and iterative shifts driven through alu_iter_shifter.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   reset_n,
  seq_alu_if.slave bus,
  output logic   busy,
  output state_e state_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

  logic             accept, start_shift, sh_done;
  logic [WIDTH-1:0] sh_result;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_ans;
  logic             alu_carry, alu_ovf;

  assign shamt        = bus.in_b[SHW-1:0];
  assign bus.in_ready = (state_q == ST_IDLE) && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    sum       = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    diff      = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    alu_ans   = bus.in_a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_ans   = sum[MSB:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (bus.in_a[MSB] == bus.in_b[MSB]) && (sum[MSB] != bus.in_a[MSB]);
      end
      OP_SUB: begin
        alu_ans   = diff[MSB:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (bus.in_a[MSB] != bus.in_b[MSB]) && (diff[MSB] != bus.in_a[MSB]);
      end
      OP_OR:   alu_ans = bus.in_a | bus.in_b;
      OP_AND:  alu_ans = bus.in_a & bus.in_b;
      OP_SLT:  alu_ans = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      // Zero-amount shifts fall through here and return in_a.
      default: alu_ans = bus.in_a;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    start_shift = 1'b0;
    valid_d     = valid_q && !bus.out_ready;
    ans_d       = ans_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op(bus.op) && (shamt != '0)) begin
            start_shift = 1'b1;
            state_d     = ST_SHIFT;
          end else begin
            valid_d = 1'b1;
            ans_d   = alu_ans;
            zero_d  = (alu_ans == '0);
            carry_d = alu_carry;
            ovf_d   = alu_ovf;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          valid_d = 1'b1;
          ans_d   = sh_result;
          zero_d  = (sh_result == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      ans_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ans_q   <= ans_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  alu_iter_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_shift),
    .step_i   (state_q == ST_SHIFT),
    .op_i     (bus.op),
    .val_i    (bus.in_a),
    .amt_i    (shamt),
    .done_o   (sh_done),
    .result_o (sh_result)
  );

  assign bus.out_valid = valid_q;
  assign bus.out_ans   = ans_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_carry = carry_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = (state_q == ST_SHIFT);
  assign state_o       = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu: directed corner cases then random traffic,
// checked against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic   clk;
  logic   reset_n;
  logic   busy;
  state_e state_o;
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  bit     rand_ready = 0;

  logic [W+2:0] exp_q[$];
  int           cyc_q[$];

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Packed as {ovf, carry, zero, ans}.
  function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c, v;
    longint       sa, sb, ss;
    int           n;
    sa = $signed(a);
    sb = $signed(b);
    n  = int'(b[4:0]);
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = (longint'(a) + longint'(b)) > 64'sd4294967295;
        ss = sa + sb;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        c  = a < b;
        ss = sa - sb;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = a << n;
      3'd5: r = a >> n;
      3'd6: r = $unsigned($signed(a) >>> n);
      default: r = ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
    return {v, c, (r == 0), r};
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [W-1:0] b);
    if (op >= 3'd4 && op <= 3'd6 && b[4:0] != 0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_result, output int waits);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.in_a     = a;
    bus.in_b     = b;
    waits        = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 100) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: in_ready low for %0d cycles, expected accept", waits);
        break;
      end
    end
    if (waits <= 100 && expect_result) begin
      exp_q.push_back(model(op, a, b));
      cyc_q.push_back(cyc + latency(op, b));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W+2:0] cur_exp;
  bit           held = 0;

  initial begin
    logic [W+2:0] act;
    forever begin
      @(negedge clk);
      if (reset_n && bus.out_valid) begin
        act = {bus.out_ovf, bus.out_carry, bus.out_zero, bus.out_ans};
        if (!held) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h with no result outstanding", act);
          end else begin
            cur_exp = exp_q.pop_front();
            check("result", act, cur_exp);
            check("latency", (W+3)'(cyc), (W+3)'(cyc_q.pop_front()));
          end
        end else begin
          check("hold_stable", act, cur_exp);
        end
      end
      held = reset_n && bus.out_valid && !bus.out_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int           waits;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", (W+3)'({bus.out_valid, bus.out_ovf, bus.out_carry, bus.out_zero, bus.out_ans}), '0);
    check("reset_busy_state", (W+3)'({busy, state_o}), (W+3)'({1'b0, ST_IDLE}));
    check("reset_in_ready", (W+3)'(bus.in_ready), (W+3)'(1));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1, waits);
    issue(OP_SUB, 32'h8000_0000, 32'd1, 1, waits);
    issue(OP_SUB, 32'd3, 32'd5, 1, waits);

    issue(OP_SRA, 32'hF000_0000, 32'd4, 1, waits);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("sra_busy_stall", (W+3)'({busy, bus.in_ready}), (W+3)'(2'b10));
    end
    @(negedge clk);
    check("sra_busy_done", (W+3)'(busy), '0);
    @(posedge clk);
    #1;

    issue(OP_SLL, 32'h1234_5678, 32'd0, 1, waits);
    @(negedge clk);
    check("sll0_no_busy", (W+3)'(busy), '0);
    @(posedge clk);
    #1;

    // Backpressure: hold the AND result, then release while a new op waits.
    bus.out_ready = 1'b0;
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1, waits);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", (W+3)'({bus.out_valid, bus.in_ready}), (W+3)'(2'b10));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue(OP_OR, 32'h0000_00F0, 32'h0000_000F, 1, waits);
    check("bp_same_edge_accept", (W+3)'(waits), '0);

    // Reset in the middle of a long shift: nothing may come out.
    issue(OP_SLL, 32'h0000_0001, 32'd10, 0, waits);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_reset", (W+3)'({bus.out_valid, busy, state_o}), (W+3)'({1'b0, 1'b0, ST_IDLE}));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(OP_ADD, 32'd2, 32'd3, 1, waits);

    // Random traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb[4:0] = 5'd0;
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) rb = ~ra + 1;
      issue(rop, ra, rb, 1, waits);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Generalised to WIDTH bits and eight operations, with a registered result and status flags.
- Shifts run as a multi-cycle, one-bit-per-cycle iterative unit.
- Sits between operand issue logic and the writeback stage, using valid/ready on both sides so it can stall either way.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).
- SHW, $clog2(WIDTH), shift-amount width. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; bits [SHW-1:0] are the shift amount for shift ops.
- op  in  3  operation code.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts the result.
- out_ans  out  WIDTH  result.
- out_zero  out  1  out_ans == 0.
- out_carry  out  1  ADD: carry-out. SUB: borrow (in_a < in_b unsigned). Otherwise 0.
- out_ovf  out  1  signed overflow for ADD/SUB. Otherwise 0.
- busy  out  1  high while in SHIFT state.

Behaviour:
- Opcodes:
  - 000 ADD, 001 SUB, 010 OR, 011 AND.
  - 100 SLL, 101 SRL, 110 SRA.
  - 111 SLT: signed; result is 1 or 0, zero-extended.
- Reset (reset_n low, asynchronous): state=IDLE, out_valid=0, out_ans=0, all flags=0, busy=0, shift counter=0.
  - Reset mid-shift aborts the operation; no result is produced.
- FSM states: IDLE, SHIFT.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
  - This allows back-to-back issue while the previous result drains in the same cycle.
- Accept = in_valid && in_ready, sampled at the rising edge.
- Non-shift op, or shift op with shamt==0:
  - Result and flags are registered at the accept edge.
  - out_valid=1 from the next cycle (latency 1). State stays IDLE.
  - A zero-amount shift returns in_a.
- Shift op with shamt N>0:
  - At accept: latch in_a, op and N; go to SHIFT; busy=1.
  - Each SHIFT cycle shifts the working value one bit and decrements the counter.
  - SLL/SRL fill with 0; SRA replicates the MSB.
  - After N shift cycles: load out_ans, set out_valid, return to IDLE.
  - Result is visible N+1 cycles after accept.
- Output register:
  - out_* hold stable while out_valid && !out_ready.
  - out_valid clears on an out_ready handshake unless a new result loads on the same edge; the new result wins.
- in_a/in_b/op are ignored whenever in_ready=0.
- Flags:
  - Computed over WIDTH bits; arithmetic is modulo 2^WIDTH.
  - ADD ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - SUB ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
  - out_zero is valid for every op.

Decomposition:
- Package alu_pkg holds:
  - the eight opcode localparams;
  - the FSM state encoding (IDLE, SHIFT);
  - a helper function that classifies shift ops.
- One sub-module: alu_iter_shifter.
  - Contains the working register, down-counter and shift direction/fill logic.
  - Start/done interface; the FSM in seq_alu drives it.
- Combinational ADD/SUB/logic/SLT stays in seq_alu.

Test Plan:
- WIDTH=32. ADD a=0xFFFFFFFF, b=1 -> ans=0, zero=1, carry=1, ovf=0, one cycle after accept.
- SUB a=0x80000000, b=1 -> ans=0x7FFFFFFF, ovf=1, carry=0. Then SUB a=3, b=5 -> ans=0xFFFFFFFE, carry=1.
- SRA a=0xF0000000, b=4 -> busy for 4 cycles, in_ready=0 throughout; ans=0xFF000000 at cycle 5.
- SLL with b=0 -> ans=a at latency 1; busy never asserted.
- Backpressure: out_ready=0 holds the AND result (a=0xF0F0, b=0xFF00 -> 0xF000) stable for 3 cycles with in_ready=0. Raising out_ready with in_valid high gives an accept on that same edge.
- Assert reset_n low at cycle 2 of an SLL b=10 -> out_valid=0 and state IDLE immediately. After release, a fresh ADD 2+3 returns 5 at latency 1.
